// File: rtl/dec_pwm_if.sv
// rtl/dec_pwm_if.sv - pulse input and active-low result handshake bundle for dec_pwm
interface dec_pwm_if;
    logic       in;
    logic       rfd;
    logic       dav_;
    logic [7:0] data;
    logic       ovf;
    logic       lost;

    modport master (output in, rfd, input dav_, data, ovf, lost);
    modport slave  (input in, rfd, output dav_, data, ovf, lost);
endinterface

// File: rtl/dec_pwm.sv
// rtl/dec_pwm.sv - pulse-length decoder with saturating count and active-low handshake
module dec_pwm (
    input  logic     clock,
    input  logic     reset_,
    dec_pwm_if.slave bus
);
    typedef enum logic [2:0] {
        ARM  = 3'd0,
        IDLE = 3'd1,
        MEAS = 3'd2,
        HS1  = 3'd3,
        HS2  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       ovfr_q, ovfr_d;
    logic       ovf_q, ovf_d;
    logic       dav_q, dav_d;
    logic       lost_q, lost_d;
    logic       in_q, in_d;
    logic       busy;

    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (!bus.in) state_d = IDLE;
            IDLE:    if (bus.in)  state_d = MEAS;
            MEAS:    if (!bus.in) state_d = HS1;
            HS1:     if (!bus.rfd) state_d = HS2;
            HS2:     if (bus.rfd) state_d = ARM;
            default: state_d = ARM;
        endcase
    end

    assign busy = (state_q == ARM) || (state_q == HS1) || (state_q == HS2);

    always_comb begin
        cnt_d  = cnt_q;
        ovfr_d = ovfr_q;
        data_d = data_q;
        ovf_d  = ovf_q;
        dav_d  = dav_q;
        lost_d = 1'b0;
        in_d   = bus.in;
        case (state_q)
            IDLE: begin
                if (bus.in) begin
                    cnt_d  = 8'd1;
                    ovfr_d = 1'b0;
                end
            end
            MEAS: begin
                if (bus.in) begin
                    if (cnt_q == 8'd255) ovfr_d = 1'b1;
                    else                 cnt_d  = cnt_q + 8'd1;
                end else begin
                    data_d = cnt_q;
                    ovf_d  = ovfr_q;
                    dav_d  = 1'b0;
                end
            end
            HS1: begin
                if (!bus.rfd) dav_d = 1'b1;
            end
            default: ;
        endcase
        // A rise seen while busy is flagged but never measured; ARM swallows its tail.
        if (busy && bus.in && !in_q) lost_d = 1'b1;
    end

    // in_q resets high so a pulse already present at reset release is not a rise.
    always_ff @(posedge clock or posedge reset_) begin
        if (reset_) begin
            cnt_q  <= 8'd0;
            ovfr_q <= 1'b0;
            data_q <= 8'd0;
            ovf_q  <= 1'b0;
            dav_q  <= 1'b1;
            lost_q <= 1'b0;
            in_q   <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            ovfr_q <= ovfr_d;
            data_q <= data_d;
            ovf_q  <= ovf_d;
            dav_q  <= dav_d;
            lost_q <= lost_d;
            in_q   <= in_d;
        end
    end

    assign bus.dav_ = dav_q;
    assign bus.data = data_q;
    assign bus.ovf  = ovf_q;
    assign bus.lost = lost_q;
endmodule

// File: tb/tb_dec_pwm.sv
// tb/tb_dec_pwm.sv - directed self-checking bench for dec_pwm
module tb_dec_pwm;
    logic clock;
    logic reset_;
    int   vectors;
    int   miscompares;
    int   lost_cnt;
    int   falls;
    logic dav_prev;

    dec_pwm_if bus ();

    dec_pwm dut (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        lost_cnt = 0;
        falls    = 0;
        dav_prev = 1'b1;
    end

    always @(posedge clock) begin
        if (!reset_) begin
            if (bus.lost === 1'b1) lost_cnt = lost_cnt + 1;
            if (bus.dav_ === 1'b0 && dav_prev === 1'b1) falls = falls + 1;
        end
        dav_prev = bus.dav_;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors = vectors + 1;
        assert (obs === exp_v) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input int n, input logic [7:0] exp_data, input logic exp_ovf, input string tag);
        for (int i = 0; i < n; i++) begin
            bus.in = 1'b1;
            @(negedge clock);
        end
        bus.in = 1'b0;
        check({tag, "_dav_pre"}, {31'd0, bus.dav_}, 32'd1);
        @(negedge clock);
        check({tag, "_dav"}, {31'd0, bus.dav_}, 32'd0);
        check({tag, "_data"}, {24'd0, bus.data}, {24'd0, exp_data});
        check({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    endtask

    task automatic ack(input string tag);
        cyc(1);
        check({tag, "_dav_hold"}, {31'd0, bus.dav_}, 32'd0);
        bus.rfd = 1'b0;
        @(negedge clock);
        check({tag, "_dav_rel"}, {31'd0, bus.dav_}, 32'd1);
        bus.rfd = 1'b1;
        cyc(2);
    endtask

    initial begin
        int x1;
        int x2;
        vectors     = 0;
        miscompares = 0;
        reset_      = 1'b1;
        bus.in      = 1'b0;
        bus.rfd     = 1'b1;
        #1;
        check("rst_dav", {31'd0, bus.dav_}, 32'd1);
        check("rst_data", {24'd0, bus.data}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        check("rst_lost", {31'd0, bus.lost}, 32'd0);
        cyc(3);
        reset_ = 1'b0;
        cyc(2);

        pulse(5, 8'd5, 1'b0, "p5");
        ack("p5");
        check("p5_data_after", {24'd0, bus.data}, 32'd5);

        pulse(1, 8'd1, 1'b0, "p1");
        ack("p1");
        pulse(255, 8'd255, 1'b0, "p255");
        ack("p255");

        pulse(300, 8'd255, 1'b1, "p300");
        ack("p300");
        check("p300_data_after", {24'd0, bus.data}, 32'd255);
        check("p300_ovf_after", {31'd0, bus.ovf}, 32'd1);
        check("falls_a", falls, 32'd4);

        pulse(7, 8'd7, 1'b0, "p7");
        cyc(2);
        bus.in = 1'b1;
        @(negedge clock);
        check("lost_hi", {31'd0, bus.lost}, 32'd1);
        @(negedge clock);
        check("lost_lo", {31'd0, bus.lost}, 32'd0);
        cyc(2);
        bus.in = 1'b0;
        cyc(14);
        check("p7_data_hold", {24'd0, bus.data}, 32'd7);
        check("p7_dav_hold", {31'd0, bus.dav_}, 32'd0);
        ack("p7");
        cyc(3);
        check("p7_no_second", {31'd0, bus.dav_}, 32'd1);
        check("lost_count_a", lost_cnt, 32'd1);
        check("falls_b", falls, 32'd5);

        bus.in = 1'b1;
        cyc(2);
        reset_ = 1'b1;
        #1;
        check("mid_rst_dav", {31'd0, bus.dav_}, 32'd1);
        check("mid_rst_data", {24'd0, bus.data}, 32'd0);
        @(negedge clock);
        reset_ = 1'b0;
        cyc(7);
        bus.in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("mid_rst_nodav", {31'd0, bus.dav_}, 32'd1);
        end
        check("falls_c", falls, 32'd5);
        pulse(4, 8'd4, 1'b0, "p4");
        ack("p4");

        x1 = 10;
        x2 = 21;
        pulse((x1 + x2) / 2, 8'd15, 1'b0, "avg");
        ack("avg");
        x1 = 0;
        x2 = 0;
        bus.rfd = 1'b0;
        for (int i = 0; i < (x1 + x2) / 2; i++) begin
            bus.in = 1'b1;
            @(negedge clock);
        end
        bus.in = 1'b0;
        cyc(5);
        bus.rfd = 1'b1;
        cyc(5);
        check("zero_dav", {31'd0, bus.dav_}, 32'd1);
        check("zero_data", {24'd0, bus.data}, 32'd15);
        check("falls_d", falls, 32'd7);
        check("lost_count_b", lost_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
